// File: rtl/serial_to_parallel_flex.sv
// Serial-to-parallel converter that packs lane_w-bit beats into width-bit words.
// It supports a one-word output slot with backpressure and a flush that emits a partial word.
module serial_to_parallel_flex #(
  parameter int width     = 8,
  parameter int lane_w    = 1,
  parameter int msb_first = 0
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 serial_valid,
  input  logic [lane_w-1:0]                    serial_data,
  output logic                                 serial_ready,
  input  logic                                 flush,
  output logic                                 parallel_valid,
  input  logic                                 parallel_ready,
  output logic [width-1:0]                     parallel_data,
  output logic [$clog2(width/lane_w+1)-1:0]    parallel_count
);

  localparam int N  = width / lane_w;
  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] LAST_BEAT = CW'(N - 1);
  localparam logic [CW-1:0] FULL_CNT  = CW'(N);

  if (lane_w < 1 || (width % lane_w) != 0) begin : g_bad_params
    $error("serial_to_parallel_flex: width must be a non-zero multiple of lane_w");
  end

  logic [width-1:0] acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             valid_q, valid_d;
  logic [width-1:0] data_q, data_d;
  logic [CW-1:0]    count_q, count_d;

  logic [width-1:0] acc_beat;
  logic             slot_free;
  logic             accept;
  logic             full;
  logic             flush_load;

  // The last beat may only enter when the slot can take the finished word.
  assign serial_ready   = !((cnt_q == LAST_BEAT) && valid_q && !parallel_ready);
  assign slot_free      = !valid_q || parallel_ready;
  assign parallel_valid = valid_q;
  assign parallel_data  = data_q;
  assign parallel_count = count_q;

  always_comb begin
    acc_beat = acc_q;
    for (int k = 0; k < N; k++) begin
      if (cnt_q == CW'(k)) begin
        acc_beat[(msb_first != 0 ? width - (k + 1) * lane_w : k * lane_w) +: lane_w] = serial_data;
      end
    end

    accept     = serial_valid && serial_ready;
    full       = accept && (cnt_q == LAST_BEAT);
    flush_load = flush && slot_free && !full && ((cnt_q != '0) || accept);

    acc_d   = acc_q;
    cnt_d   = cnt_q;
    valid_d = valid_q && !parallel_ready;
    data_d  = data_q;
    count_d = count_q;

    if (accept) begin
      acc_d = acc_beat;
      cnt_d = cnt_q + CW'(1);
    end

    // A completed word takes precedence over flush on the same edge.
    if (full) begin
      valid_d = 1'b1;
      data_d  = acc_beat;
      count_d = FULL_CNT;
      acc_d   = '0;
      cnt_d   = '0;
    end else if (flush_load) begin
      valid_d = 1'b1;
      data_d  = accept ? acc_beat : acc_q;
      count_d = accept ? cnt_q + CW'(1) : cnt_q;
      acc_d   = '0;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q   <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
      count_q <= '0;
    end else begin
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      count_q <= count_d;
    end
  end

endmodule

// File: tb/tb_serial_to_parallel_flex.sv
// Self-checking bench for serial_to_parallel_flex: four configurations checked every cycle
// against a beat-list model, plus hand-computed word values for the key scenarios.
module tb_serial_to_parallel_flex;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Group A drives the two 8x1 instances; group B drives the 16x4 and 4x4 instances.
  logic       a_valid = 1'b0, a_flush = 1'b0, a_pready = 1'b0;
  logic [0:0] a_data  = '0;
  logic       b_valid = 1'b0, b_flush = 1'b0, b_pready = 1'b0;
  logic [3:0] b_data  = '0;

  logic        p0_sready, p0_valid;
  logic [7:0]  p0_data;
  logic [3:0]  p0_count;
  logic        p1_sready, p1_valid;
  logic [7:0]  p1_data;
  logic [3:0]  p1_count;
  logic        p2_sready, p2_valid;
  logic [15:0] p2_data;
  logic [2:0]  p2_count;
  logic        p3_sready, p3_valid;
  logic [3:0]  p3_data;
  logic [0:0]  p3_count;

  serial_to_parallel_flex #(.width(8), .lane_w(1), .msb_first(0)) dut_lsb (
    .clk(clk), .rst(rst), .serial_valid(a_valid), .serial_data(a_data), .serial_ready(p0_sready),
    .flush(a_flush), .parallel_valid(p0_valid), .parallel_ready(a_pready),
    .parallel_data(p0_data), .parallel_count(p0_count));

  serial_to_parallel_flex #(.width(8), .lane_w(1), .msb_first(1)) dut_msb (
    .clk(clk), .rst(rst), .serial_valid(a_valid), .serial_data(a_data), .serial_ready(p1_sready),
    .flush(a_flush), .parallel_valid(p1_valid), .parallel_ready(a_pready),
    .parallel_data(p1_data), .parallel_count(p1_count));

  serial_to_parallel_flex #(.width(16), .lane_w(4), .msb_first(0)) dut_nib (
    .clk(clk), .rst(rst), .serial_valid(b_valid), .serial_data(b_data), .serial_ready(p2_sready),
    .flush(b_flush), .parallel_valid(p2_valid), .parallel_ready(b_pready),
    .parallel_data(p2_data), .parallel_count(p2_count));

  serial_to_parallel_flex #(.width(4), .lane_w(4), .msb_first(0)) dut_one (
    .clk(clk), .rst(rst), .serial_valid(b_valid), .serial_data(b_data), .serial_ready(p3_sready),
    .flush(b_flush), .parallel_valid(p3_valid), .parallel_ready(b_pready),
    .parallel_data(p3_data), .parallel_count(p3_count));

  int act_pv[4], act_data[4], act_cnt[4], act_sr[4];
  assign act_pv[0] = 32'(p0_valid);  assign act_data[0] = 32'(p0_data);
  assign act_cnt[0] = 32'(p0_count); assign act_sr[0] = 32'(p0_sready);
  assign act_pv[1] = 32'(p1_valid);  assign act_data[1] = 32'(p1_data);
  assign act_cnt[1] = 32'(p1_count); assign act_sr[1] = 32'(p1_sready);
  assign act_pv[2] = 32'(p2_valid);  assign act_data[2] = 32'(p2_data);
  assign act_cnt[2] = 32'(p2_count); assign act_sr[2] = 32'(p2_sready);
  assign act_pv[3] = 32'(p3_valid);  assign act_data[3] = 32'(p3_data);
  assign act_cnt[3] = 32'(p3_count); assign act_sr[3] = 32'(p3_sready);

  int checks = 0;
  int errors = 0;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got 'h%0h, expected 'h%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Model: a list of beats for the current word and one output slot per instance.
  int          mw[4] = '{8, 8, 16, 4};
  int          ml[4] = '{1, 1, 4, 4};
  int          mm[4] = '{0, 1, 0, 0};
  int          mbeat[4][16];
  int          mcnt[4];
  logic        mvalid[4];
  int          mdata[4];
  int          mcount[4];
  bit          live = 1'b0;

  function automatic logic grp_pready(input int i);
    return (i < 2) ? a_pready : b_pready;
  endfunction

  function automatic logic exp_ready(input int i);
    int n;
    n = mw[i] / ml[i];
    return !(mcnt[i] == n - 1 && mvalid[i] && !grp_pready(i));
  endfunction

  function automatic int pack(input int i, input int cnt);
    int d, pos;
    d = 0;
    for (int k = 0; k < cnt; k++) begin
      pos = (mm[i] != 0) ? mw[i] - (k + 1) * ml[i] : k * ml[i];
      d = d | (mbeat[i][k] << pos);
    end
    return d;
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      int n, sd;
      logic sv, fl, pr, sr, free, acc;
      n  = mw[i] / ml[i];
      sv = (i < 2) ? a_valid : b_valid;
      fl = (i < 2) ? a_flush : b_flush;
      pr = grp_pready(i);
      sd = (i < 2) ? 32'(a_data) : 32'(b_data);
      if (rst) begin
        mvalid[i] = 1'b0; mdata[i] = 0; mcount[i] = 0; mcnt[i] = 0;
      end else begin
        sr   = exp_ready(i);
        free = !mvalid[i] || pr;
        if (mvalid[i] && pr) mvalid[i] = 1'b0;
        acc = sv && sr;
        if (acc) begin
          mbeat[i][mcnt[i]] = sd;
          mcnt[i]++;
        end
        if (acc && mcnt[i] == n) begin
          mdata[i] = pack(i, n); mcount[i] = n; mvalid[i] = 1'b1; mcnt[i] = 0;
        end else if (fl && free && mcnt[i] > 0) begin
          mdata[i] = pack(i, mcnt[i]); mcount[i] = mcnt[i]; mvalid[i] = 1'b1; mcnt[i] = 0;
        end
      end
    end
    live = 1'b1;
  end

  always @(negedge clk) begin
    if (live) begin
      for (int i = 0; i < 4; i++) begin
        checkOutput($sformatf("model_valid%0d", i), act_pv[i], 32'(mvalid[i]));
        if (mvalid[i]) begin
          checkOutput($sformatf("model_data%0d", i), act_data[i], mdata[i]);
          checkOutput($sformatf("model_count%0d", i), act_cnt[i], mcount[i]);
        end
        checkOutput($sformatf("model_sready%0d", i), act_sr[i], 32'(exp_ready(i)));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input int grp, input logic v, input logic [3:0] d,
                               input logic f, input logic pr);
    if (grp == 0) begin
      a_valid = v; a_data = d[0]; a_flush = f; a_pready = pr;
    end else begin
      b_valid = v; b_data = d; b_flush = f; b_pready = pr;
    end
  endtask

  initial begin
    logic [7:0] pat;
    logic [7:0] pat_b;

    rst = 1'b1;
    tick(); tick();
    checkOutput("reset_valid", 32'(p0_valid), 0);
    checkOutput("reset_data", 32'(p0_data), 0);
    checkOutput("reset_count", 32'(p0_count), 0);
    rst = 1'b0;
    #1;
    checkOutput("reset_sready", 32'(p0_sready), 1);

    // Word 1,0,1,1,0,0,1,0 in both lane orders.
    pat = 8'h4D;
    for (int k = 0; k < 8; k++) begin
      applyStimulus(0, 1'b1, {3'b0, pat[k]}, 1'b0, 1'b1);
      tick();
    end
    checkOutput("lsb_valid", 32'(p0_valid), 1);
    checkOutput("lsb_data", 32'(p0_data), 'h4D);
    checkOutput("lsb_count", 32'(p0_count), 8);
    checkOutput("msb_data", 32'(p1_data), 'hB2);
    applyStimulus(0, 1'b0, 4'h0, 1'b0, 1'b1);
    tick();
    checkOutput("lsb_valid_one_cycle", 32'(p0_valid), 0);

    // Partial word 1,1,0 then flush; a second flush with nothing held does nothing.
    pat = 8'h03;
    for (int k = 0; k < 3; k++) begin
      applyStimulus(0, 1'b1, {3'b0, pat[k]}, 1'b0, 1'b1);
      tick();
    end
    applyStimulus(0, 1'b0, 4'h0, 1'b1, 1'b1);
    tick();
    checkOutput("flush_valid", 32'(p0_valid), 1);
    checkOutput("flush_data", 32'(p0_data), 'h03);
    checkOutput("flush_count", 32'(p0_count), 3);
    checkOutput("flush_msb_data", 32'(p1_data), 'hC0);
    tick();
    checkOutput("flush_empty_valid", 32'(p0_valid), 0);
    tick();
    checkOutput("flush_empty_valid2", 32'(p0_valid), 0);

    // Backpressure: word A held while word B fills up to its last beat.
    pat   = 8'hA5;
    pat_b = 8'h3C;
    for (int k = 0; k < 8; k++) begin
      applyStimulus(0, 1'b1, {3'b0, pat[k]}, 1'b0, 1'b0);
      tick();
    end
    checkOutput("bp_a_valid", 32'(p0_valid), 1);
    checkOutput("bp_a_data", 32'(p0_data), 'hA5);
    for (int k = 0; k < 7; k++) begin
      applyStimulus(0, 1'b1, {3'b0, pat_b[k]}, 1'b0, 1'b0);
      tick();
      checkOutput("bp_a_stable", 32'(p0_data), 'hA5);
    end
    applyStimulus(0, 1'b1, {3'b0, pat_b[7]}, 1'b0, 1'b0);
    #1;
    checkOutput("bp_sready_low", 32'(p0_sready), 0);
    tick();
    checkOutput("bp_a_still_valid", 32'(p0_valid), 1);
    checkOutput("bp_a_still_data", 32'(p0_data), 'hA5);
    checkOutput("bp_a_still_count", 32'(p0_count), 8);
    applyStimulus(0, 1'b1, {3'b0, pat_b[7]}, 1'b0, 1'b1);
    tick();
    checkOutput("bp_b_valid", 32'(p0_valid), 1);
    checkOutput("bp_b_data", 32'(p0_data), 'h3C);
    checkOutput("bp_b_count", 32'(p0_count), 8);
    applyStimulus(0, 1'b0, 4'h0, 1'b0, 1'b1);
    tick();
    checkOutput("bp_drained", 32'(p0_valid), 0);

    // Reset discards a partial word of five beats.
    for (int k = 0; k < 5; k++) begin
      applyStimulus(0, 1'b1, 4'h1, 1'b0, 1'b1);
      tick();
    end
    applyStimulus(0, 1'b0, 4'h0, 1'b0, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("rst_mid_valid", 32'(p0_valid), 0);
    for (int k = 0; k < 8; k++) begin
      applyStimulus(0, 1'b1, 4'h1, 1'b0, 1'b1);
      tick();
    end
    checkOutput("rst_ff_data", 32'(p0_data), 'hFF);
    checkOutput("rst_ff_count", 32'(p0_count), 8);
    applyStimulus(0, 1'b0, 4'h0, 1'b0, 1'b1);

    // Nibble lanes: 16-bit word from 1,2,3,4; the N=1 instance emits every beat.
    for (int k = 1; k <= 4; k++) begin
      applyStimulus(1, 1'b1, 4'(k), 1'b0, 1'b1);
      tick();
      checkOutput("n1_valid", 32'(p3_valid), 1);
      checkOutput("n1_data", 32'(p3_data), k);
      checkOutput("n1_count", 32'(p3_count), 1);
    end
    checkOutput("nib_data", 32'(p2_data), 'h4321);
    checkOutput("nib_count", 32'(p2_count), 4);
    for (int k = 0; k < 16; k++) begin
      applyStimulus(1, 1'b1, 4'(k), 1'b0, 1'b1);
      tick();
      checkOutput("nib_stream_valid", 32'(p2_valid), ((k % 4) == 3) ? 1 : 0);
      checkOutput("n1_stream_valid", 32'(p3_valid), 1);
    end

    // Mixed random traffic with flush, stalls and the odd reset, judged by the model.
    for (int c = 0; c < 400; c++) begin
      applyStimulus(0, $urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)),
                    $urandom_range(0, 7) == 0, $urandom_range(0, 3) != 0);
      applyStimulus(1, $urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)),
                    $urandom_range(0, 7) == 0, $urandom_range(0, 2) != 0);
      rst = ($urandom_range(0, 149) == 0);
      tick();
    end
    rst = 1'b0;
    applyStimulus(0, 1'b0, 4'h0, 1'b0, 1'b1);
    applyStimulus(1, 1'b0, 4'h0, 1'b0, 1'b1);
    tick(); tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
